modport_fifo: RTL and testbench

MODPORT_FIFO -- requirements
Module: modport_fifo

---
 rtl/modport_fifo_if.sv | 46 ++++
 rtl/modport_fifo.sv | 87 ++++++++
 tb/tb_modport_fifo.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/modport_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : modport_fifo_if
// Description : Handshake bundle for modport_fifo; the master drives requests
//               and the slave (the FIFO) returns data and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface modport_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    logic                         wr;
    logic                         rd;
    logic [WIDTH-1:0]             din;
    logic [WIDTH-1:0]             dout;
    logic                         empty;
    logic                         full;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         overflow;
    logic                         underflow;

    modport master (
        output wr,
        output rd,
        output din,
        input  dout,
        input  empty,
        input  full,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  wr,
        input  rd,
        input  din,
        output dout,
        output empty,
        output full,
        output count,
        output overflow,
        output underflow
    );
endinterface
`default_nettype wire

// File: rtl/modport_fifo.sv
`default_nettype none
// ============================================================================
// Module      : modport_fifo
// Description : Synchronous FIFO with registered read data, occupancy count
//               and one-cycle overflow/underflow pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module modport_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire           clk,
    input  wire           rst,
    modport_fifo_if.slave bus
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] c_PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] c_CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic [AW-1:0]    w_wr_ptr_nxt;
    logic [AW-1:0]    w_rd_ptr_nxt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_FULL);

    // A write into a full FIFO is only legal when the same edge frees a slot.
    assign w_rd_ok = bus.rd && !w_empty;
    assign w_wr_ok = bus.wr && (!w_full || w_rd_ok);

    assign w_wr_ptr_nxt = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + AW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + AW'(1);

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_mem[r_wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_dout      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= w_rd_ptr_nxt;
                r_dout   <= r_mem[r_rd_ptr];
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_overflow  <= bus.wr && w_full && !bus.rd;
            r_underflow <= bus.rd && w_empty;
        end
    end

    assign bus.dout      = r_dout;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_modport_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_modport_fifo
// Description : Directed self-checking bench for modport_fifo (8 x 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modport_fifo;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    modport_fifo_if #(.WIDTH(8), .DEPTH(16)) bus ();

    modport_fifo #(.WIDTH(8), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, then settle before sampling.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        bus.wr  = w;
        bus.rd  = r;
        bus.din = d;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 1'b0, 8'hAA);
        step(1'b1, 1'b0, 8'hAA);
        rst = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", bus.full); end
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
        checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_flags got=%0b%0b exp=00", bus.overflow, bus.underflow); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 8'(i));
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got=%0b exp=1", bus.full); end
        checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_count got=%0d exp=16", bus.count); end
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            checks++; if (bus.dout !== 8'(i)) begin errors++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, bus.dout, 8'(i)); end
            checks++; if (bus.count !== 5'(16 - i)) begin errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, bus.count, 16 - i); end
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%0b exp=1", bus.empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
        step(1'b1, 1'b0, 8'hFF);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%0b exp=1", bus.overflow); end
        checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", bus.count); end
        step(1'b0, 1'b0, 8'h00);
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got=%0b exp=0", bus.overflow); end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            checks++; if (bus.dout !== 8'(8'h20 + i)) begin errors++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, bus.dout, 8'(8'h20 + i)); end
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got=%0b exp=1", bus.empty); end
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b1, 8'h00);
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL udf_pulse got=%0b exp=1", bus.underflow); end
        checks++; if (bus.dout !== 8'h2F) begin errors++; $display("FAIL udf_dout got=%h exp=2f", bus.dout); end
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL udf_count got=%0d exp=0", bus.count); end
        step(1'b0, 1'b0, 8'h00);
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL udf_one_cycle got=%0b exp=0", bus.underflow); end
    endtask

    task automatic test_simul_empty();
        step(1'b1, 1'b1, 8'h55);
        checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL sim_empty_count got=%0d exp=1", bus.count); end
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL sim_empty_udf got=%0b exp=1", bus.underflow); end
        checks++; if (bus.dout !== 8'h2F) begin errors++; $display("FAIL sim_empty_dout got=%h exp=2f", bus.dout); end
        step(1'b0, 1'b1, 8'h00);
        checks++; if (bus.dout !== 8'h55) begin errors++; $display("FAIL sim_empty_read got=%h exp=55", bus.dout); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL sim_empty_after got=%0b exp=1", bus.empty); end
    endtask

    task automatic test_simul_full();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        step(1'b1, 1'b1, 8'h99);
        checks++; if (bus.dout !== 8'h40) begin errors++; $display("FAIL sim_full_dout got=%h exp=40", bus.dout); end
        checks++; if (bus.count !== 5'd16 || bus.full !== 1'b1) begin errors++; $display("FAIL sim_full_count got=%0d/%0b exp=16/1", bus.count, bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL sim_full_ovf got=%0b exp=0", bus.overflow); end
        for (int i = 1; i <= 16; i++) begin
            exp = (i == 16) ? 8'h99 : 8'(8'h40 + i);
            step(1'b0, 1'b1, 8'h00);
            checks++; if (bus.dout !== exp) begin errors++; $display("FAIL sim_full_drain[%0d] got=%h exp=%h", i, bus.dout, exp); end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 8'(i));
            step(1'b0, 1'b1, 8'h00);
            checks++; if (bus.dout !== 8'(i)) begin errors++; $display("FAIL wrap_dout[%0d] got=%h exp=%h", i, bus.dout, 8'(i)); end
        end
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL wrap_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
        rst = 1'b1;
        step(1'b1, 1'b1, 8'h66);
        rst = 1'b0;
        checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL midrst_state got=%0d/%0b exp=0/1", bus.count, bus.empty); end
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL midrst_dout got=%h exp=00", bus.dout); end
        step(1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b1, 8'h00);
        checks++; if (bus.dout !== 8'h77) begin errors++; $display("FAIL midrst_read got=%h exp=77", bus.dout); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got=%0b exp=1", bus.empty); end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
        bus.din = 8'h00;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_simul_empty();
        test_simul_full();
        test_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
